// File: rtl/alu_pkg.sv
// Shared definitions for the shared RItype ALU: widths, aluSelect codes and FSM state.
package alu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned SEL_W     = 6;
    localparam int unsigned GNT_CNT_W = 16;

    // Immediate forms: operand b carries the already-extended immediate.
    localparam logic [SEL_W-1:0] ALU_ADDI  = 6'd19;
    localparam logic [SEL_W-1:0] ALU_SLTI  = 6'd20;
    localparam logic [SEL_W-1:0] ALU_SLTIU = 6'd21;
    localparam logic [SEL_W-1:0] ALU_XORI  = 6'd22;
    localparam logic [SEL_W-1:0] ALU_ORI   = 6'd23;
    localparam logic [SEL_W-1:0] ALU_ANDI  = 6'd24;
    localparam logic [SEL_W-1:0] ALU_SLLI  = 6'd25;
    localparam logic [SEL_W-1:0] ALU_SRLI  = 6'd26;
    localparam logic [SEL_W-1:0] ALU_SRAI  = 6'd27;
    // Register forms.
    localparam logic [SEL_W-1:0] ALU_ADD   = 6'd28;
    localparam logic [SEL_W-1:0] ALU_SLL   = 6'd29;
    localparam logic [SEL_W-1:0] ALU_SLT   = 6'd30;
    localparam logic [SEL_W-1:0] ALU_SLTU  = 6'd31;
    localparam logic [SEL_W-1:0] ALU_XOR   = 6'd32;
    localparam logic [SEL_W-1:0] ALU_SRL   = 6'd33;
    localparam logic [SEL_W-1:0] ALU_OR    = 6'd34;
    localparam logic [SEL_W-1:0] ALU_AND   = 6'd35;
    localparam logic [SEL_W-1:0] ALU_SUB   = 6'd36;
    localparam logic [SEL_W-1:0] ALU_SRA   = 6'd37;

    localparam logic [SEL_W-1:0] ALU_SEL_MIN = 6'd19;
    localparam logic [SEL_W-1:0] ALU_SEL_MAX = 6'd37;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational RItype integer ALU.
//   a, b    : operands (b is the immediate for the I-forms)
//   sel     : aluSelect code
//   result  : ALU output, zero for an illegal code
//   illegal : sel is outside the legal set
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [SEL_W-1:0] sel,
    output logic [XLEN-1:0]  result,
    output logic             illegal
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Operation decode; unlisted codes fall through to the illegal default.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (sel)
            ALU_ADDI,  ALU_ADD:  result = a + b;
            ALU_SUB:             result = a - b;
            ALU_SLTI,  ALU_SLT:  result = XLEN'(lt_s);
            ALU_SLTIU, ALU_SLTU: result = XLEN'(lt_u);
            ALU_XORI,  ALU_XOR:  result = a ^ b;
            ALU_ORI,   ALU_OR:   result = a | b;
            ALU_ANDI,  ALU_AND:  result = a & b;
            ALU_SLLI,  ALU_SLL:  result = a << shamt;
            ALU_SRLI,  ALU_SRL:  result = a >> shamt;
            ALU_SRAI,  ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            default:             illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one RItype ALU between two requesters with a
// single registered, ID-tagged response channel and grant counters.
//   clk, rst_n                          : clock, async active-low reset
//   r0_* / r1_*                         : valid/ready request ports with a, b, sel
//   rsp_valid/ready, rsp_id             : response handshake and issuing requester
//   rsp_result, rsp_illegal             : registered ALU result and illegal-code flag
//   gnt_cnt0, gnt_cnt1                  : saturating accepted-operation counters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = GNT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [XLEN-1:0]  r0_a,
    input  logic [XLEN-1:0]  r0_b,
    input  logic [SEL_W-1:0] r0_sel,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [XLEN-1:0]  r1_a,
    input  logic [XLEN-1:0]  r1_b,
    input  logic [SEL_W-1:0] r1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    rsp_state_e       state;
    logic             rr_ptr;
    logic             can_accept;
    logic             winner;
    logic             accept;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [XLEN-1:0]  alu_result;
    logic             alu_illegal;

    // Arbitration: a lone requester wins, contention resolves by rr_ptr.
    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        winner     = (r0_valid && r1_valid) ? rr_ptr : r1_valid;
        accept     = can_accept && (r0_valid || r1_valid);
        r0_ready   = can_accept && r0_valid && !winner;
        r1_ready   = can_accept && r1_valid && winner;
        alu_a      = winner ? r1_a   : r0_a;
        alu_b      = winner ? r1_b   : r0_b;
        alu_sel    = winner ? r1_sel : r0_sel;
    end

    alu_share_arbiter_alu u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .sel     (alu_sel),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    assign rsp_valid = (state == FULL);

    // Response FSM, response register, round-robin pointer and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            rr_ptr      <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_illegal <= 1'b0;
            gnt_cnt0    <= '0;
            gnt_cnt1    <= '0;
        end else begin
            if (accept) begin
                state       <= FULL;
                rsp_id      <= winner;
                rsp_result  <= alu_result;
                rsp_illegal <= alu_illegal;
                rr_ptr      <= ~winner;
                if (!winner && (gnt_cnt0 != '1)) begin
                    gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
                end
                if (winner && (gnt_cnt1 != '1)) begin
                    gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
                end
            end else if ((state == FULL) && rsp_ready) begin
                // Result consumed with nothing new: drop to EMPTY, keep last value.
                state <= EMPTY;
            end
        end
    end

endmodule
